// File: rtl/cva6_tlb_pkg.sv
// Shared types and constants for the Sv32 TLB: the packed update-bus layout,
// the per-entry tag, PTE bit positions and a VPN-compare helper.
package cva6_tlb_pkg;

  localparam int unsigned VPN1_W     = 10;
  localparam int unsigned VPN0_W     = 10;
  localparam int unsigned ASID_MAX_W = 9;
  localparam int unsigned PTE_W      = 32;
  localparam int unsigned PTE_G_BIT  = 5;
  localparam int unsigned PTE_V_BIT  = 0;

  // Mirrors update_i[62:0] from MSB to LSB
  typedef struct packed {
    logic                  valid;
    logic                  is_4M;
    logic [VPN1_W-1:0]     vpn1;
    logic [VPN0_W-1:0]     vpn0;
    logic [ASID_MAX_W-1:0] asid;
    logic [PTE_W-1:0]      content;
  } tlb_update_t;

  // Stored ASID keeps all 9 bits; bits above ASID_WIDTH are always written as zero
  typedef struct packed {
    logic                  valid;
    logic                  is_4M;
    logic [VPN1_W-1:0]     vpn1;
    logic [VPN0_W-1:0]     vpn0;
    logic [ASID_MAX_W-1:0] asid;
  } tlb_tag_t;

  // Superpages match on vpn1 alone; 4 KiB pages need vpn1 and vpn0
  function automatic logic vpn_match(input logic              is_4M,
                                     input logic [VPN1_W-1:0] vpn1,
                                     input logic [VPN0_W-1:0] vpn0,
                                     input logic [19:0]       va_vpn);
    return (vpn1 == va_vpn[19:10]) && (is_4M || (vpn0 == va_vpn[9:0]));
  endfunction

endpackage

// File: rtl/cva6_tlb_plru.sv
// Tree pseudo-LRU for the TLB. Node bit 0 points the victim search to the
// left (lower-index) half, 1 to the right. An accessed entry flips every node
// on its path to point away from it. Invalid entries take precedence.
module cva6_tlb_plru #(
  parameter int unsigned TLB_ENTRIES = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [TLB_ENTRIES-1:0] i_hit,
  input  logic                   i_access,
  input  logic [TLB_ENTRIES-1:0] i_valid,
  output logic [TLB_ENTRIES-1:0] o_victim
);

  localparam int unsigned LVLS  = $clog2(TLB_ENTRIES);
  localparam int unsigned NODES = TLB_ENTRIES - 1;
  localparam logic [TLB_ENTRIES-1:0] ONE_N = {{(TLB_ENTRIES-1){1'b0}}, 1'b1};

  logic [NODES-1:0]       r_tree;
  logic [NODES-1:0]       w_tree_nxt;
  logic [NODES-1:0]       w_hit_lo;
  logic [NODES-1:0]       w_hit_hi;
  logic [TLB_ENTRIES-1:0] w_plru_vic;
  logic [TLB_ENTRIES-1:0] w_inv;
  logic [TLB_ENTRIES-1:0] w_inv_oh;

  for (genvar l = 0; l < LVLS; l++) begin : g_lvl
    for (genvar p = 0; p < (1 << l); p++) begin : g_node
      localparam int unsigned NODE = (1 << l) - 1 + p;
      localparam int unsigned HALF = TLB_ENTRIES >> (l + 1);
      localparam int unsigned BASE = p * (TLB_ENTRIES >> l);
      assign w_hit_lo[NODE]   = |i_hit[BASE +: HALF];
      assign w_hit_hi[NODE]   = |i_hit[BASE + HALF +: HALF];
      assign w_tree_nxt[NODE] = !i_access      ? r_tree[NODE] :
                                w_hit_lo[NODE] ? 1'b1 :
                                w_hit_hi[NODE] ? 1'b0 : r_tree[NODE];
    end
  end

  for (genvar i = 0; i < TLB_ENTRIES; i++) begin : g_vic
    logic [LVLS-1:0] w_ok;
    for (genvar l = 0; l < LVLS; l++) begin : g_path
      localparam int unsigned NODE = (1 << l) - 1 + (i >> (LVLS - l));
      localparam logic        DIR  = ((i >> (LVLS - l - 1)) & 1) != 0;
      assign w_ok[l] = (r_tree[NODE] == DIR);
    end
    assign w_plru_vic[i] = &w_ok;
  end

  assign w_inv    = ~i_valid;
  assign w_inv_oh = w_inv & (~w_inv + ONE_N);
  assign o_victim = (|w_inv) ? w_inv_oh : w_plru_vic;

  // Tree state: cleared on reset, otherwise follows accessed hits
  always_ff @(posedge i_clk) begin
    if (i_rst) r_tree <= '0;
    else       r_tree <= w_tree_nxt;
  end

endmodule

// File: rtl/cva6_tlb_sv32.sv
// Fully associative Sv32 TLB with combinational lookup, PTW update bus,
// SFENCE.VMA-style flush and tree-PLRU replacement.
// Optional macro CVA6_TLB_GLOBAL_EN: when defined, PTE.G makes an entry match
// any ASID and protects it from ASID-qualified flushes; otherwise G is ignored.
module cva6_tlb_sv32
  import cva6_tlb_pkg::*;
#(
  parameter int unsigned TLB_ENTRIES = 4,
  parameter int unsigned ASID_WIDTH  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [62:0]           update_i,
  input  logic                  lu_access_i,
  input  logic [ASID_WIDTH-1:0] lu_asid_i,
  input  logic [31:0]           lu_vaddr_i,
  output logic [31:0]           lu_content_o,
  input  logic [ASID_WIDTH-1:0] asid_to_be_flushed_i,
  input  logic [31:0]           vaddr_to_be_flushed_i,
  output logic                  lu_is_4M_o,
  output logic                  lu_hit_o
);

  localparam logic [TLB_ENTRIES-1:0] ONE_N     = {{(TLB_ENTRIES-1){1'b0}}, 1'b1};
  localparam logic [ASID_MAX_W-1:0]  ASID_MASK = ASID_MAX_W'((1 << ASID_WIDTH) - 1);

  tlb_update_t             w_upd;
  tlb_tag_t                r_tag     [TLB_ENTRIES];
  logic [PTE_W-1:0]        r_content [TLB_ENTRIES];
  logic [ASID_MAX_W-1:0]   w_lu_asid;
  logic [ASID_MAX_W-1:0]   w_fl_asid;
  logic                    w_fl_all_asid;
  logic                    w_fl_all_va;
  logic [TLB_ENTRIES-1:0]  w_hit;
  logic [TLB_ENTRIES-1:0]  w_hit_oh;
  logic [TLB_ENTRIES-1:0]  w_flush_inv;
  logic [TLB_ENTRIES-1:0]  w_valid;
  logic [TLB_ENTRIES-1:0]  w_victim;
  logic                    w_unused_vaddr;

  assign w_upd          = update_i;
  assign w_lu_asid      = ASID_MAX_W'(lu_asid_i);
  assign w_fl_asid      = ASID_MAX_W'(asid_to_be_flushed_i);
  assign w_fl_all_asid  = (asid_to_be_flushed_i == '0);
  assign w_fl_all_va    = (vaddr_to_be_flushed_i == '0);
  assign w_unused_vaddr = ^lu_vaddr_i[11:0];

  for (genvar i = 0; i < TLB_ENTRIES; i++) begin : g_entry
    logic w_g;
    logic w_lu_vpn;
    logic w_fl_vpn;
    logic w_fl_asid_hit;
`ifdef CVA6_TLB_GLOBAL_EN
    assign w_g = r_content[i][PTE_G_BIT];
`else
    assign w_g = 1'b0;
`endif
    assign w_lu_vpn = vpn_match(r_tag[i].is_4M, r_tag[i].vpn1, r_tag[i].vpn0,
                                lu_vaddr_i[31:12]);
    assign w_fl_vpn = vpn_match(r_tag[i].is_4M, r_tag[i].vpn1, r_tag[i].vpn0,
                                vaddr_to_be_flushed_i[31:12]);
    assign w_valid[i]    = r_tag[i].valid;
    assign w_hit[i]      = r_tag[i].valid && ((r_tag[i].asid == w_lu_asid) || w_g) && w_lu_vpn;
    assign w_fl_asid_hit = (r_tag[i].asid == w_fl_asid) && !w_g;
    // Zero flush ASID / address act as wildcards for their half of the match
    assign w_flush_inv[i] = (w_fl_all_asid || w_fl_asid_hit) && (w_fl_all_va || w_fl_vpn);
  end

  // Duplicates are legal; the lowest-index hit drives the outputs and the PLRU
  assign w_hit_oh = w_hit & (~w_hit + ONE_N);

  // Output mux over the single winning entry; all zero on a miss
  always_comb begin
    lu_hit_o     = |w_hit;
    lu_content_o = '0;
    lu_is_4M_o   = 1'b0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (w_hit_oh[i]) begin
        lu_content_o = r_content[i];
        lu_is_4M_o   = r_tag[i].is_4M;
      end
    end
  end

  cva6_tlb_plru #(
    .TLB_ENTRIES (TLB_ENTRIES)
  ) u_plru (
    .i_clk    (clk_i),
    .i_rst    (rst_ni),
    .i_hit    (w_hit_oh),
    .i_access (lu_access_i),
    .i_valid  (w_valid),
    .o_victim (w_victim)
  );

  // Entry state: reset beats flush, flush beats update; only valid bits are reset
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (rst_ni) begin
        r_tag[i].valid <= 1'b0;
      end else if (flush_i) begin
        if (w_flush_inv[i]) r_tag[i].valid <= 1'b0;
      end else if (w_upd.valid && w_victim[i]) begin
        r_tag[i].valid <= 1'b1;
        r_tag[i].is_4M <= w_upd.is_4M;
        r_tag[i].vpn1  <= w_upd.vpn1;
        r_tag[i].vpn0  <= w_upd.vpn0;
        r_tag[i].asid  <= w_upd.asid & ASID_MASK;
        r_content[i]   <= w_upd.content;
      end
    end
  end

endmodule

// File: tb/tb_cva6_tlb_sv32.sv
// Directed testbench for cva6_tlb_sv32 (4 entries, 1-bit ASID).
// Honours CVA6_TLB_GLOBAL_EN when choosing expected values for G=1 entries.
module tb_cva6_tlb_sv32;
  import cva6_tlb_pkg::*;

  localparam logic [31:0] PTE_VG = (32'h1 << PTE_G_BIT) | (32'h1 << PTE_V_BIT);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [62:0] upd = '0;
  logic        lu_access = 1'b0;
  logic [0:0]  lu_asid = '0;
  logic [31:0] lu_vaddr = '0;
  logic [31:0] lu_content;
  logic [0:0]  fasid = '0;
  logic [31:0] fvaddr = '0;
  logic        lu_is4m;
  logic        lu_hit;
  logic [33:0] obs;

  int total = 0;
  int bad   = 0;

  assign obs = {lu_hit, lu_is4m, lu_content};

  always #5 clk = ~clk;

  cva6_tlb_sv32 #(
    .TLB_ENTRIES (4),
    .ASID_WIDTH  (1)
  ) dut (
    .clk_i                 (clk),
    .rst_ni                (rst),
    .flush_i               (flush),
    .update_i              (upd),
    .lu_access_i           (lu_access),
    .lu_asid_i             (lu_asid),
    .lu_vaddr_i            (lu_vaddr),
    .lu_content_o          (lu_content),
    .asid_to_be_flushed_i  (fasid),
    .vaddr_to_be_flushed_i (fvaddr),
    .lu_is_4M_o            (lu_is4m),
    .lu_hit_o              (lu_hit)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic is4m, input logic [19:0] vpn,
                         input logic [8:0] asid, input logic [31:0] pte);
    upd = {1'b1, is4m, vpn, asid, pte};
  endtask

  task automatic write(input logic is4m, input logic [19:0] vpn,
                       input logic [8:0] asid, input logic [31:0] pte);
    set_upd(is4m, vpn, asid, pte);
    tick();
    upd = '0;
  endtask

  task automatic look(input logic [31:0] va, input logic [0:0] a);
    lu_vaddr = va;
    lu_asid  = a;
    #1;
  endtask

  task automatic hit_access(input logic [31:0] va, input logic [0:0] a);
    lu_access = 1'b1;
    look(va, a);
    tick();
    lu_access = 1'b0;
  endtask

  task automatic flush_op(input logic [0:0] a, input logic [31:0] va);
    fasid  = a;
    fvaddr = va;
    flush  = 1'b1;
    tick();
    flush  = 1'b0;
    fasid  = '0;
    fvaddr = '0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    lu_access = 1'b1;
    look(32'h12345000, 1'b1);
    total++;
    if (obs !== 34'h0) begin bad++; $display("FAIL reset_lookup_a1 got=%h exp=%h", obs, 34'h0); end
    look(32'h00000000, 1'b0);
    total++;
    if (obs !== 34'h0) begin bad++; $display("FAIL reset_lookup_a0 got=%h exp=%h", obs, 34'h0); end
    lu_access = 1'b0;
  endtask

  task automatic test_basic();
    logic [33:0] exp;
    set_upd(1'b0, 20'h12345, 9'd1, 32'hDEADBEE1);
    look(32'h12345000, 1'b1);
    total++;
    if (obs !== 34'h0) begin bad++; $display("FAIL upd_pre_edge got=%h exp=%h", obs, 34'h0); end
    tick();
    upd = '0;
    look(32'h12345000, 1'b1);
    exp = {1'b1, 1'b0, 32'hDEADBEE1};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL basic_hit got=%h exp=%h", obs, exp); end
    // 0xDEADBEE1 has G set: matches any ASID only when G is honoured
    look(32'h12345000, 1'b0);
`ifdef CVA6_TLB_GLOBAL_EN
    exp = {1'b1, 1'b0, 32'hDEADBEE1};
`else
    exp = 34'h0;
`endif
    total++;
    if (obs !== exp) begin bad++; $display("FAIL basic_other_asid got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_4m();
    logic [31:0] va  [4];
    logic [33:0] exp [4];
    write(1'b1, {10'h048, 10'h000}, 9'd1, 32'h00000001);
    va  = '{32'h12000000, 32'h123FF000, 32'h12400000, 32'h12345000};
    exp = '{{1'b1, 1'b1, 32'h00000001}, {1'b1, 1'b1, 32'h00000001}, 34'h0,
            {1'b1, 1'b0, 32'hDEADBEE1}};
    for (int k = 0; k < 4; k++) begin
      look(va[k], 1'b1);
      total++;
      if (obs !== exp[k]) begin
        bad++; $display("FAIL superpage[%0d] va=%h got=%h exp=%h", k, va[k], obs, exp[k]);
      end
    end
  endtask

  task automatic fill_1_to_4();
    pulse_reset();
    for (int k = 1; k <= 4; k++) write(1'b0, 20'(k), 9'd1, 32'h100 + 32'(k));
  endtask

  task automatic test_plru();
    logic [33:0] exp;
    // Hits on e0,e1,e2 leave the root pointing left and node1 at e0: vpn 1 is the victim
    fill_1_to_4();
    hit_access(32'h00001000, 1'b1);
    hit_access(32'h00002000, 1'b1);
    hit_access(32'h00003000, 1'b1);
    write(1'b0, 20'h00005, 9'd1, 32'h105);
    for (int k = 1; k <= 5; k++) begin
      look(32'(k) << 12, 1'b1);
      exp = (k == 1) ? 34'h0 : {1'b1, 1'b0, 32'h100 + 32'(k)};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL plru_order123 vpn=%0d got=%h exp=%h", k, obs, exp); end
    end
    // Hits on e2,e0,e1 leave root pointing right and node2 at e3: vpn 4 is the victim
    fill_1_to_4();
    hit_access(32'h00003000, 1'b1);
    hit_access(32'h00001000, 1'b1);
    hit_access(32'h00002000, 1'b1);
    write(1'b0, 20'h00005, 9'd1, 32'h105);
    for (int k = 1; k <= 5; k++) begin
      look(32'(k) << 12, 1'b1);
      exp = (k == 4) ? 34'h0 : {1'b1, 1'b0, 32'h100 + 32'(k)};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL plru_order312 vpn=%0d got=%h exp=%h", k, obs, exp); end
    end
  endtask

  task automatic test_flush();
    logic [33:0] exp;
    int          vp [4];
    // Flush-all with four valid entries; lookups in the flush cycle still see them
    fasid = '0; fvaddr = '0; flush = 1'b1;
    look(32'h00001000, 1'b1);
    exp = {1'b1, 1'b0, 32'h101};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL flush_pre_edge got=%h exp=%h", obs, exp); end
    tick();
    flush = 1'b0;
    vp = '{1, 2, 3, 5};
    for (int k = 0; k < 4; k++) begin
      look(32'(vp[k]) << 12, 1'b1);
      total++;
      if (obs !== 34'h0) begin bad++; $display("FAIL flush_all vpn=%0d got=%h exp=%h", vp[k], obs, 34'h0); end
    end
    write(1'b0, 20'h12345, 9'd1, 32'h0000A001);
    write(1'b0, 20'h12345, 9'd0, 32'h0000B001);
    write(1'b0, 20'h22222, 9'd1, 32'h0000C001);
    write(1'b0, 20'h12345, 9'd1, 32'h0000D000 | PTE_VG);
    look(32'h12345000, 1'b1);
    exp = {1'b1, 1'b0, 32'h0000A001};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL pre_flush_a1 got=%h exp=%h", obs, exp); end
    flush_op(1'b1, 32'h12345000);
    look(32'h12345000, 1'b1);
`ifdef CVA6_TLB_GLOBAL_EN
    exp = {1'b1, 1'b0, 32'h0000D000 | PTE_VG};
`else
    exp = 34'h0;
`endif
    total++;
    if (obs !== exp) begin bad++; $display("FAIL flush_asid_va_a1 got=%h exp=%h", obs, exp); end
    look(32'h12345000, 1'b0);
    exp = {1'b1, 1'b0, 32'h0000B001};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL flush_asid_va_keep_a0 got=%h exp=%h", obs, exp); end
    look(32'h22222000, 1'b1);
    exp = {1'b1, 1'b0, 32'h0000C001};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL flush_asid_va_keep_vpn got=%h exp=%h", obs, exp); end
    // Address-only flush hits every ASID
    flush_op(1'b0, 32'h22222000);
    look(32'h22222000, 1'b1);
    total++;
    if (obs !== 34'h0) begin bad++; $display("FAIL flush_va_only got=%h exp=%h", obs, 34'h0); end
    // ASID-only flush spares other ASIDs (and G entries when honoured)
    flush_op(1'b1, 32'h0);
    look(32'h12345000, 1'b0);
    exp = {1'b1, 1'b0, 32'h0000B001};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL flush_asid_only_a0 got=%h exp=%h", obs, exp); end
    look(32'h12345000, 1'b1);
`ifdef CVA6_TLB_GLOBAL_EN
    exp = {1'b1, 1'b0, 32'h0000D000 | PTE_VG};
`else
    exp = 34'h0;
`endif
    total++;
    if (obs !== exp) begin bad++; $display("FAIL flush_asid_only_a1 got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_collision();
    logic [33:0] exp;
    // Flush matching nothing still blocks the concurrent update
    set_upd(1'b0, 20'h00010, 9'd1, 32'h00000011);
    fasid = 1'b1; fvaddr = 32'h33333000; flush = 1'b1;
    tick();
    flush = 1'b0; fasid = '0; fvaddr = '0; upd = '0;
    look(32'h00010000, 1'b1);
    total++;
    if (obs !== 34'h0) begin bad++; $display("FAIL flush_beats_update got=%h exp=%h", obs, 34'h0); end
    look(32'h12345000, 1'b0);
    exp = {1'b1, 1'b0, 32'h0000B001};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL flush_nomatch_keep got=%h exp=%h", obs, exp); end
    write(1'b0, 20'h00010, 9'd1, 32'h00000011);
    look(32'h00010000, 1'b1);
    exp = {1'b1, 1'b0, 32'h00000011};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL update_after_flush got=%h exp=%h", obs, exp); end
    // Reset mid-sequence, with an update pending in the same cycle
    rst = 1'b1;
    set_upd(1'b0, 20'h00020, 9'd1, 32'h00000021);
    tick();
    rst = 1'b0;
    upd = '0;
    look(32'h00010000, 1'b1);
    total++;
    if (obs !== 34'h0) begin bad++; $display("FAIL reset_mid_vpn10 got=%h exp=%h", obs, 34'h0); end
    look(32'h00020000, 1'b1);
    total++;
    if (obs !== 34'h0) begin bad++; $display("FAIL reset_beats_update got=%h exp=%h", obs, 34'h0); end
    look(32'h12345000, 1'b0);
    total++;
    if (obs !== 34'h0) begin bad++; $display("FAIL reset_mid_b got=%h exp=%h", obs, 34'h0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_4m();
    test_plru();
    test_flush();
    test_collision();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
